mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_bus_if.sv | 31 +++
 rtl/mem_array.sv | 30 +++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and defaults for the mem_responder slice.
//   state_t        - responder FSM state encoding (also exported for debug)
//   DEF_RESULTADR  - default address of the result-capture location
//   DEF_EXPECTED   - default value a result write is compared against
//   WAITSTATES_MAX - largest supported wait-state count
//   CNT_W          - width of the wait-state counter
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0]  DEF_RESULTADR  = 8'hFF;
  localparam logic [7:0]  DEF_EXPECTED   = 8'h0D;
  localparam int unsigned WAITSTATES_MAX = 15;
  localparam int unsigned CNT_W          = 4;

endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: processor <-> memory request/response bus.
//   memread, memwrite - request strobes from the processor
//   adr, writedata    - request address and write data
//   memdata           - read data returned to the processor
//   ready             - one-cycle completion strobe from the memory
//
// Handshake: a request (memread or memwrite high) acts as "valid" and must
// be held, together with adr/writedata, until the cycle in which ready is
// high. ready is the completion strobe; the transfer completes at the
// rising edge that ends that cycle. A request still high after that edge
// is taken as a new access.
interface mem_bus_if #(
  parameter int unsigned WIDTH = 8
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             ready;

  modport master (
    output memread, memwrite, adr, writedata,
    input  memdata, ready
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    output memdata, ready
  );
endinterface

// File: rtl/mem_array.sv
// mem_array: 2**WIDTH x WIDTH storage, synchronous write, combinational read.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational)
// Contents are not reset; a location is undefined until first written.
module mem_array #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated memory model answering a simple processor bus,
// with a result-capture location that reports done/pass.
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-low
//   bus       - mem_bus_if slave side (memread/memwrite/adr/writedata in,
//               memdata/ready out)
//   done      - sticky: a write to RESULTADR has occurred since reset
//   pass      - last write to RESULTADR equalled EXPECTED
//   dbg_state - current FSM state
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      WAITSTATES = 2,
  parameter logic [WIDTH-1:0] RESULTADR  = WIDTH'(DEF_RESULTADR),
  parameter logic [WIDTH-1:0] EXPECTED   = WIDTH'(DEF_EXPECTED)
) (
  input  logic      clk,
  input  logic      reset,
  mem_bus_if.slave  bus,
  output logic      done,
  output logic      pass,
  output state_t    dbg_state
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   cap_adr;
  logic [WIDTH-1:0]   cap_wdata;
  logic               cap_wr;
  logic [WIDTH-1:0]   memdata_q;
  logic [WIDTH-1:0]   rd_data;
  logic               capture;
  logic               access;
  logic               mem_we;

  // Request inputs are only looked at while idle; during WAIT/RESP the
  // captured copies are used, so the initiator may change the bus freely.
  assign capture = (state == IDLE) && (bus.memread || bus.memwrite);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.memread || bus.memwrite) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // The access happens on the edge that leaves WAIT, so WAITSTATES=0
        // still spends exactly one cycle here.
        if (cnt == '0) begin
          state_next = RESP;
          access     = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write enable is derived from the FSM, so an asynchronous reset during
  // WAIT (which forces IDLE) can never let the abandoned write land.
  assign mem_we = access && cap_wr;

  mem_array #(
    .WIDTH (WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cap_adr),
    .wdata (cap_wdata),
    .raddr (cap_adr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      cap_adr   <= '0;
      cap_wdata <= '0;
      cap_wr    <= 1'b0;
      memdata_q <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      if (capture) begin
        cnt       <= CNT_W'(WAITSTATES);
        cap_adr   <= bus.adr;
        cap_wdata <= bus.writedata;
        // Simultaneous read and write requests resolve to a write.
        cap_wr    <= bus.memwrite;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (access) begin
        if (cap_wr) begin
          if (cap_adr == RESULTADR) begin
            done <= 1'b1;
            pass <= (cap_wdata == EXPECTED);
          end
        end else begin
          // memdata only changes on read completion; writes leave it alone.
          memdata_q <= rd_data;
        end
      end
    end
  end

  assign bus.memdata = memdata_q;
  assign bus.ready   = (state == RESP);
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder (default parameters)
// plus a second instance with WAITSTATES=0.
module tb_mem_responder;
  import mem_bus_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_bus_if #(.WIDTH(8)) bus0 ();
  mem_bus_if #(.WIDTH(8)) bus1 ();

  logic   done0, pass0, done1, pass1;
  state_t st0, st1;

  mem_responder #(
    .WIDTH      (8),
    .WAITSTATES (2),
    .RESULTADR  (8'hFF),
    .EXPECTED   (8'h0D)
  ) u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus0.slave),
    .done      (done0),
    .pass      (pass0),
    .dbg_state (st0)
  );

  mem_responder #(
    .WIDTH      (8),
    .WAITSTATES (0),
    .RESULTADR  (8'hFF),
    .EXPECTED   (8'h0D)
  ) u_dut_ws0 (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus1.slave),
    .done      (done1),
    .pass      (pass1),
    .dbg_state (st1)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Issue one access on bus0, hold it until ready, return the number of
  // rising edges from the capture edge to the first cycle with ready high.
  // With chg set, adr/writedata are altered right after capture.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic chg, input logic [7:0] alt,
                        output int lat);
    @(negedge clk);
    bus0.memread   = rd;
    bus0.memwrite  = wr;
    bus0.adr       = a;
    bus0.writedata = d;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus0.ready || lat >= 40) break;
      if (lat == 0 && chg) begin
        bus0.adr       = alt;
        bus0.writedata = ~d;
      end
      @(posedge clk);
      lat++;
    end
    bus0.memread  = 1'b0;
    bus0.memwrite = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", 32'(bus0.ready), 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    int lat;
    access(1'b0, 1'b1, a, d, 1'b0, 8'h00, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp,
                         input logic chg, input logic [7:0] alt);
    int lat;
    logic [7:0] e;
    exp_q.push_back(exp);
    access(1'b1, 1'b0, a, 8'h00, chg, alt, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    e = exp_q.pop_front();
    check({tag, "_data"}, 32'(bus0.memdata), 32'(e));
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int lat;
    int n_ready;
    int n_consec;
    int first_at;
    logic prev;

    rst_n          = 1'b0;
    bus0.memread   = 1'b0;
    bus0.memwrite  = 1'b0;
    bus0.adr       = 8'h00;
    bus0.writedata = 8'h00;
    bus1.memread   = 1'b0;
    bus1.memwrite  = 1'b0;
    bus1.adr       = 8'h00;
    bus1.writedata = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_ready",   32'(bus0.ready),   32'd0);
    check("rst_memdata", 32'(bus0.memdata), 32'd0);
    check("rst_done",    32'(done0),        32'd0);
    check("rst_pass",    32'(pass0),        32'd0);
    check("rst_state",   32'(st0),          32'(IDLE));
    rst_n = 1'b1;

    // Scenario 1: write then read back
    do_write("s1_wr", 8'h10, 8'h5A);
    do_read ("s1_rd", 8'h10, 8'h5A, 1'b0, 8'h00);

    // Scenario 2: result writes
    do_write("s2_wr0d", 8'hFF, 8'h0D);
    check("s2_done_a", 32'(done0), 32'd1);
    check("s2_pass_a", 32'(pass0), 32'd1);
    do_write("s2_wr0c", 8'hFF, 8'h0C);
    check("s2_done_b", 32'(done0), 32'd1);
    check("s2_pass_b", 32'(pass0), 32'd0);
    do_read ("s2_rdff", 8'hFF, 8'h0C, 1'b0, 8'h00);
    check("s2_done_c", 32'(done0), 32'd1);
    check("s2_pass_c", 32'(pass0), 32'd0);
    do_write("s2_wr0d2", 8'hFF, 8'h0D);
    check("s2_pass_d", 32'(pass0), 32'd1);

    // Scenario 4: read+write together is a write; memdata keeps 0x0C
    access(1'b1, 1'b1, 8'h30, 8'h77, 1'b0, 8'h00, lat);
    check("s4_lat", 32'(lat), 32'd3);
    check("s4_memdata_held", 32'(bus0.memdata), 32'h0C);
    do_read("s4_rd", 8'h30, 8'h77, 1'b0, 8'h00);

    // Scenario 6: address changed during WAIT is ignored
    do_write("s6_wr50", 8'h50, 8'hC3);
    do_write("s6_wr60", 8'h60, 8'h3C);
    do_read ("s6_rd", 8'h50, 8'hC3, 1'b1, 8'h60);

    // Full address range, no aliasing
    do_write("adr_wr00", 8'h00, 8'hE1);
    do_read ("adr_rdff", 8'hFF, 8'h0D, 1'b0, 8'h00);
    do_read ("adr_rd00", 8'h00, 8'hE1, 1'b0, 8'h00);

    // Scenario 5: reset during WAIT abandons the write
    do_write("s5_wr11", 8'h40, 8'h11);
    do_read ("s5_rd11", 8'h40, 8'h11, 1'b0, 8'h00);
    @(negedge clk);
    bus0.memwrite  = 1'b1;
    bus0.adr       = 8'h40;
    bus0.writedata = 8'hAA;
    @(posedge clk);
    #2;
    check("s5_in_wait", 32'(st0), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    check("s5_rst_state",   32'(st0),          32'(IDLE));
    check("s5_rst_ready",   32'(bus0.ready),   32'd0);
    check("s5_rst_memdata", 32'(bus0.memdata), 32'd0);
    check("s5_rst_done",    32'(done0),        32'd0);
    check("s5_rst_pass",    32'(pass0),        32'd0);
    bus0.memwrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus0.ready) n_ready++;
    end
    check("s5_no_ready", 32'(n_ready), 32'd0);
    do_read("s5_rd40", 8'h40, 8'h11, 1'b0, 8'h00);

    // Scenario 3: WAITSTATES=0 instance, held read
    @(negedge clk);
    bus1.memwrite  = 1'b1;
    bus1.adr       = 8'h20;
    bus1.writedata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    check("s3_wr_wait", 32'(bus1.ready), 32'd0);
    @(negedge clk);
    check("s3_wr_ready", 32'(bus1.ready), 32'd1);
    bus1.memwrite = 1'b0;
    @(negedge clk);
    bus1.memread = 1'b1;
    n_ready  = 0;
    n_consec = 0;
    first_at = 0;
    prev     = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus1.ready) begin
        n_ready++;
        if (prev) n_consec++;
        if (first_at == 0) first_at = i;
      end
      prev = bus1.ready;
      if (i == 4) bus1.memread = 1'b0;
    end
    check("s3_first_ready", 32'(first_at), 32'd2);
    check("s3_ready_count", 32'(n_ready),  32'd2);
    check("s3_consecutive", 32'(n_consec), 32'd0);
    check("s3_memdata",     32'(bus1.memdata), 32'h3C);
    check("s3_state_idle",  32'(st1), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
